mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Parametrised successor of the MEM pipeline stage. It sits between EX/MEM and MEM/WB and drives the data-memory port through a req/gnt/rvalid handshake that tolerates variable latency, instead of a fixed single-cycle port. Misaligned accesses are split into two word-aligned beats, never rotated within one word. Load data is lane-aligned and sign- or zero-extended, and the pipeline is stalled through `ex_ready` while a transaction is in flight.

## Interface
- `XLEN`, 32: data width; 32 or 64. `NB = XLEN/8` byte lanes.
- `ADDR_W`, 32: address width.
- `ALLOW_MISALIGNED`, 1: 1 splits crossing accesses into two beats; 0 flags them as errors.

- `clk`  in  1  system clock
- `Rst`  in  1  asynchronous, active-low reset
- `dbg`  in  1  debug freeze; blocks accept and WB update
- `ex_valid`  in  1  EX/MEM op present
- `ex_ready`  out  1  stage can accept; low means stall upstream
- `ex_addr`  in  ADDR_W  ALU result / effective address
- `ex_wdata`  in  XLEN  store data (rs2)
- `fwd_en`, `fwd_data`  in  1, XLEN  WB-to-store-data forward; selects `fwd_data` over `ex_wdata`
- `ex_rd`  in  5  destination register
- `ex_regwrite`, `ex_memread`, `ex_memwrite`  in  1 each  control bits
- `ex_size`  in  2  access size: 0=B, 1=H, 2=W, 3=D
- `ex_unsigned`  in  1  zero-extend load
- `mem_req`  out  1  memory request
- `mem_gnt`  in  1  request accepted
- `mem_we`  out  1  write beat
- `mem_be`  out  NB  byte enables
- `mem_addr`  out  ADDR_W  word-aligned address (low `log2(NB)` bits zero)
- `mem_wdata`  out  XLEN  lane-aligned write data
- `mem_rvalid`  in  1  beat response; read data valid, or write acknowledged
- `mem_rdata`  in  XLEN  read data
- `wb_valid`  out  1  one-cycle pulse per retired op
- `wb_regwrite`, `wb_memread`  out  1 each  registered control
- `wb_rd`  out  5  destination register
- `wb_alures`  out  ADDR_W  registered `ex_addr`
- `wb_memres`  out  XLEN  extended load result; 0 for non-loads
- `wb_err`  out  1  illegal size, or misaligned with `ALLOW_MISALIGNED=0`

## Operation
- States: IDLE, REQ0, RSP0, REQ1, RSP1, HOLD. `ex_ready = (state==IDLE) && !dbg`.
- **Accept** (IDLE, `ex_valid && ex_ready`): latch the op. Store data is latched as `fwd_en ? fwd_data : ex_wdata`.
  - Non-memory op: WB registers update at the same edge and state stays IDLE.
  - Error op: retire at the same edge with `wb_err=1`, `wb_regwrite=0`, and no memory access.
  - Memory op: go to REQ0.
- **Error conditions**:
  - `ex_size==3` with `XLEN==32` is illegal.
  - With `ALLOW_MISALIGNED=0`, an access is an error when `off % nbytes != 0`.
- **Lane mapping**: `off = addr[log2(NB)-1:0]`, `nbytes = 1<<size`.
  - Single beat when `off+nbytes <= NB`: `be = ((1<<nbytes)-1) << off`.
  - Split otherwise:
    - beat0: address `addr & ~(NB-1)`, lanes `off..NB-1`.
    - beat1: address beat0 + NB, lanes `0..off+nbytes-NB-1`.
  - `mem_wdata` is the store data rotated left by `off` bytes, the same value for both beats.
- **REQx**: `mem_req=1`. `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` stay stable until `mem_gnt`. On `mem_gnt`, go to RSPx.
- **RSPx**: wait for `mem_rvalid`.
  - On RSP0 of a split access, capture beat0 `mem_rdata` and go to REQ1.
  - On the final beat: if `!dbg`, retire and go to IDLE; otherwise capture the result and go to HOLD.
  - `mem_rvalid` outside the RSP states is ignored.
- **Load assembly**:
  - Lane i takes beat0 data when `i >= off`, else beat1 data; single-beat loads use one beat for all lanes.
  - Rotate right by `off` bytes, truncate to `nbytes`.
  - Sign-extend unless `ex_unsigned`.
- **Retire**: write the `wb_*` registers and pulse `wb_valid`. `wb_memres` is 0 for stores and non-memory ops.
- **HOLD**: retire on the first cycle with `dbg` low, then go to IDLE.
- **dbg**: never aborts an in-flight transaction. It blocks only accept and retire.

## Timing
- All outputs come from registers, except `ex_ready` (decoded from state and `dbg`).
- Reset values: state IDLE, `mem_req=0`, `mem_we=0`, `mem_be=0`, `mem_addr=0`, `mem_wdata=0`, all `wb_*` = 0.
- Asserting `Rst` low drops `mem_req` immediately and discards any in-flight op with no retire.
- Non-memory op: `wb_valid` is high in the cycle after accept, giving back-to-back throughput of 1 op per cycle.
- Memory op with zero-wait memory (`mem_gnt` in the request cycle, `mem_rvalid` the cycle after):
  - Single beat: `mem_req` asserted 1 cycle after accept; `wb_valid` 3 cycles after accept.
  - Split: `wb_valid` 5 cycles after accept.
  - Each stall cycle on `mem_gnt` or `mem_rvalid` adds one cycle.
- `wb_*` values hold between retires; only `wb_valid` pulses.

## Test plan
- Non-memory ops back-to-back with `ex_addr` = 0x10, 0x14, 0x18 -> `wb_valid` high 3 consecutive cycles; `wb_alures` = 0x10, 0x14, 0x18; `ex_ready` stays 1.
- LB at 0x1003, `mem_rdata=0x80FF_0000` (XLEN=32) -> single beat; `mem_be=4'b1000`; `mem_addr=0x1000`; `wb_memres=0xFFFF_FF80`. The same op with LBU gives `0x0000_0080`.
- SW at 0x2002, data 0xAABBCCDD, `ALLOW_MISALIGNED=1`:
  - beat0: `addr=0x2000`, `be=4'b1100`, `wdata=0xCCDDAABB`.
  - beat1: `addr=0x2004`, `be=4'b0011`, same wdata.
  - Then `wb_valid` pulses once.
- LW at 0x2002 returning beat0 `0x1122_3344`, beat1 `0x5566_7788` -> `wb_memres=0x7788_1122`. With `mem_gnt` delayed 3 cycles on beat0, `mem_addr` and `mem_be` are stable throughout and `ex_ready=0` until retire.
- LH at 0x3001 with `ALLOW_MISALIGNED=0` -> no `mem_req`; `wb_err=1`; `wb_regwrite=0`. Separately, LD with XLEN=32 -> `wb_err=1`.
- `dbg` raised during RSP0 of a single-beat load -> the transaction completes, the FSM enters HOLD, `wb_valid` stays 0, and it retires the cycle after `dbg` falls. `Rst` pulsed low during REQ0 -> `mem_req` drops asynchronously, all `wb_*` = 0, and no retire occurs.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with a req/gnt/rvalid data-memory port. Misaligned
// accesses become two word-aligned beats; load data is realigned and extended.
module mem_stage_lsu #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic                dbg,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [ADDR_W-1:0]   ex_addr,
  input  logic [XLEN-1:0]     ex_wdata,
  input  logic                fwd_en,
  input  logic [XLEN-1:0]     fwd_data,
  input  logic [4:0]          ex_rd,
  input  logic                ex_regwrite,
  input  logic                ex_memread,
  input  logic                ex_memwrite,
  input  logic [1:0]          ex_size,
  input  logic                ex_unsigned,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                wb_valid,
  output logic                wb_regwrite,
  output logic                wb_memread,
  output logic [4:0]          wb_rd,
  output logic [ADDR_W-1:0]   wb_alures,
  output logic [XLEN-1:0]     wb_memres,
  output logic                wb_err
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int LW   = 2 * NB;

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, HOLD} state_t;

  function automatic logic [XLEN-1:0] rotl_bytes(input logic [XLEN-1:0] d,
                                                 input logic [OFFW-1:0] sh);
    logic [2*XLEN-1:0] dd;
    dd = {d, d} << {sh, 3'b000};
    return dd[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] rotr_bytes(input logic [XLEN-1:0] d,
                                                 input logic [OFFW-1:0] sh);
    logic [2*XLEN-1:0] dd;
    dd = {d, d} >> {sh, 3'b000};
    return dd[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                             input logic [1:0] sz, input logic uns);
    logic [XLEN-1:0] m;
    logic            s;
    case (sz)
      2'd0:    begin m = XLEN'(8'hFF);         s = d[7];      end
      2'd1:    begin m = XLEN'(16'hFFFF);      s = d[15];     end
      2'd2:    begin m = XLEN'(32'hFFFF_FFFF); s = d[31];     end
      default: begin m = '1;                   s = d[XLEN-1]; end
    endcase
    return (d & m) | ({XLEN{s & ~uns}} & ~m);
  endfunction

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [NB-1:0]     mem_be_q, mem_be_d, be1_q, be1_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, addr_q, addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d, buf0_q, buf0_d, res_q, res_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d, split_q, split_d, regwrite_q, regwrite_d;
  logic              memread_q, memread_d;
  logic [4:0]        rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic              wb_valid_q, wb_valid_d, wb_regwrite_q, wb_regwrite_d;
  logic              wb_memread_q, wb_memread_d, wb_err_q, wb_err_d;
  logic [ADDR_W-1:0] wb_alures_q, wb_alures_d;
  logic [XLEN-1:0]   wb_memres_q, wb_memres_d;

  logic [OFFW-1:0]   ex_off, ex_nbm1;
  logic [LW-1:0]     ex_lanes;
  logic              ex_mem, ex_err;
  logic [XLEN-1:0]   hi_lanes, assembled, load_res;
  logic              final_beat, do_ret;
  logic [XLEN-1:0]   ret_res;

  // Decode of the incoming op: lane mask spanning up to two words, error check
  always_comb begin
    ex_off = ex_addr[OFFW-1:0];
    case (ex_size)
      2'd0:    begin ex_lanes = LW'(1);     ex_nbm1 = '0;         end
      2'd1:    begin ex_lanes = LW'(3);     ex_nbm1 = OFFW'(1);   end
      2'd2:    begin ex_lanes = LW'(15);    ex_nbm1 = OFFW'(3);   end
      default: begin ex_lanes = LW'(8'hFF); ex_nbm1 = OFFW'(3'd7); end
    endcase
    ex_lanes = ex_lanes << ex_off;
    ex_mem   = ex_memread | ex_memwrite;
    ex_err   = ex_mem && ((ex_size == 2'd3 && XLEN == 32) ||
                          (ALLOW_MISALIGNED == 0 && (|(ex_off & ex_nbm1))));
  end

  // Lanes at or above the offset come from beat0 on a split load
  always_comb begin
    hi_lanes  = {XLEN{1'b1}} << {off_q, 3'b000};
    assembled = split_q ? ((buf0_q & hi_lanes) | (mem_rdata & ~hi_lanes)) : mem_rdata;
    load_res  = memread_q ? extend(rotr_bytes(assembled, off_q), size_q, uns_q) : '0;
  end

  assign ex_ready = (state_q == IDLE) && !dbg;

  always_comb begin
    state_d = state_q;         mem_req_d = mem_req_q;     mem_we_d = mem_we_q;
    mem_be_d = mem_be_q;       mem_addr_d = mem_addr_q;   mem_wdata_d = mem_wdata_q;
    be1_d = be1_q;             addr_d = addr_q;           buf0_d = buf0_q;
    res_d = res_q;             off_d = off_q;             size_d = size_q;
    uns_d = uns_q;             split_d = split_q;         regwrite_d = regwrite_q;
    memread_d = memread_q;     rd_d = rd_q;               wb_rd_d = wb_rd_q;
    wb_regwrite_d = wb_regwrite_q;  wb_memread_d = wb_memread_q;  wb_err_d = wb_err_q;
    wb_alures_d = wb_alures_q; wb_memres_d = wb_memres_q;
    wb_valid_d = 1'b0;
    final_beat = 1'b0;
    do_ret     = 1'b0;
    ret_res    = '0;
    case (state_q)
      IDLE: if (ex_valid && ex_ready) begin
        if (!ex_mem || ex_err) begin
          wb_valid_d    = 1'b1;
          wb_regwrite_d = ex_regwrite && !ex_err;
          wb_memread_d  = ex_memread;
          wb_rd_d       = ex_rd;
          wb_alures_d   = ex_addr;
          wb_memres_d   = '0;
          wb_err_d      = ex_err;
        end else begin
          state_d     = REQ0;
          mem_req_d   = 1'b1;
          mem_we_d    = ex_memwrite;
          mem_addr_d  = {ex_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
          mem_be_d    = ex_lanes[NB-1:0];
          mem_wdata_d = rotl_bytes(fwd_en ? fwd_data : ex_wdata, ex_off);
          be1_d       = ex_lanes[LW-1:NB];
          split_d     = |ex_lanes[LW-1:NB];
          off_d       = ex_off;
          size_d      = ex_size;
          uns_d       = ex_unsigned;
          rd_d        = ex_rd;
          regwrite_d  = ex_regwrite;
          memread_d   = ex_memread;
          addr_d      = ex_addr;
        end
      end
      REQ0: if (mem_gnt) begin mem_req_d = 1'b0; state_d = RSP0; end
      RSP0: if (mem_rvalid) begin
        if (split_q) begin
          buf0_d     = mem_rdata;
          mem_req_d  = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_W'(NB);
          mem_be_d   = be1_q;
          state_d    = REQ1;
        end else begin
          final_beat = 1'b1;
        end
      end
      REQ1: if (mem_gnt) begin mem_req_d = 1'b0; state_d = RSP1; end
      RSP1: if (mem_rvalid) final_beat = 1'b1;
      HOLD: if (!dbg) begin do_ret = 1'b1; ret_res = res_q; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
    // Debug freeze parks a finished result instead of retiring it
    if (final_beat) begin
      if (dbg) begin
        res_d   = load_res;
        state_d = HOLD;
      end else begin
        do_ret  = 1'b1;
        ret_res = load_res;
        state_d = IDLE;
      end
    end
    if (do_ret) begin
      wb_valid_d    = 1'b1;
      wb_regwrite_d = regwrite_q;
      wb_memread_d  = memread_q;
      wb_rd_d       = rd_q;
      wb_alures_d   = addr_q;
      wb_memres_d   = ret_res;
      wb_err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;       mem_req_q <= 1'b0;    mem_we_q <= 1'b0;
      mem_be_q <= '0;        mem_addr_q <= '0;     mem_wdata_q <= '0;
      be1_q <= '0;           addr_q <= '0;         buf0_q <= '0;
      res_q <= '0;           off_q <= '0;          size_q <= '0;
      uns_q <= 1'b0;         split_q <= 1'b0;      regwrite_q <= 1'b0;
      memread_q <= 1'b0;     rd_q <= '0;           wb_rd_q <= '0;
      wb_valid_q <= 1'b0;    wb_regwrite_q <= 1'b0; wb_memread_q <= 1'b0;
      wb_err_q <= 1'b0;      wb_alures_q <= '0;    wb_memres_q <= '0;
    end else begin
      state_q <= state_d;    mem_req_q <= mem_req_d;   mem_we_q <= mem_we_d;
      mem_be_q <= mem_be_d;  mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
      be1_q <= be1_d;        addr_q <= addr_d;         buf0_q <= buf0_d;
      res_q <= res_d;        off_q <= off_d;           size_q <= size_d;
      uns_q <= uns_d;        split_q <= split_d;       regwrite_q <= regwrite_d;
      memread_q <= memread_d; rd_q <= rd_d;            wb_rd_q <= wb_rd_d;
      wb_valid_q <= wb_valid_d;       wb_regwrite_q <= wb_regwrite_d;
      wb_memread_q <= wb_memread_d;   wb_err_q <= wb_err_d;
      wb_alures_q <= wb_alures_d;     wb_memres_q <= wb_memres_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_be      = mem_be_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_memread  = wb_memread_q;
  assign wb_rd       = wb_rd_q;
  assign wb_alures   = wb_alures_q;
  assign wb_memres   = wb_memres_q;
  assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: vector table with a zero/variable-wait
// memory responder, plus sequences for back-to-back ops, debug freeze and reset.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        Rst, dbg, ex_valid, ex_valid_na, fwd_en;
  logic [31:0] ex_addr, ex_wdata, fwd_data, mem_rdata;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_unsigned;
  logic [1:0]  ex_size;
  logic        mem_gnt, mem_rvalid;

  logic        ex_ready, mem_req, mem_we, wb_valid, wb_regwrite, wb_memread, wb_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, wb_alures, wb_memres;
  logic [4:0]  wb_rd;

  logic        ex_ready_b, mem_req_b, mem_we_b, wb_valid_b, wb_regwrite_b, wb_memread_b, wb_err_b;
  logic [3:0]  mem_be_b;
  logic [31:0] mem_addr_b, mem_wdata_b, wb_alures_b, wb_memres_b;
  logic [4:0]  wb_rd_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) u_dut (
    .clk(clk), .Rst(Rst), .dbg(dbg), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .fwd_en(fwd_en), .fwd_data(fwd_data),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_memread(wb_memread), .wb_rd(wb_rd), .wb_alures(wb_alures),
    .wb_memres(wb_memres), .wb_err(wb_err));

  mem_stage_lsu #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) u_dut_na (
    .clk(clk), .Rst(Rst), .dbg(dbg), .ex_valid(ex_valid_na), .ex_ready(ex_ready_b),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .fwd_en(fwd_en), .fwd_data(fwd_data),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .mem_req(mem_req_b), .mem_gnt(mem_gnt), .mem_we(mem_we_b), .mem_be(mem_be_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid_b), .wb_regwrite(wb_regwrite_b),
    .wb_memread(wb_memread_b), .wb_rd(wb_rd_b), .wb_alures(wb_alures_b),
    .wb_memres(wb_memres_b), .wb_err(wb_err_b));

  typedef struct {
    string       name;
    logic        rd_op, wr_op, rw;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, rd0, rd1;
    int          gnt_dly, beats;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd, memres;
    logic        err, exp_rw;
    int          lat;
    logic        fwd;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  beat, wcnt;
    logic pend, done;
    ex_memread  = v.rd_op;
    ex_memwrite = v.wr_op;
    ex_regwrite = v.rw;
    ex_size     = v.size;
    ex_unsigned = v.uns;
    ex_addr     = v.addr;
    ex_rd       = 5'(idx + 1);
    fwd_en      = v.fwd;
    fwd_data    = v.wdata;
    ex_wdata    = v.fwd ? ~v.wdata : v.wdata;
    ex_valid    = 1'b1;
    tick();
    ex_valid = 1'b0;
    fwd_en   = 1'b0;
    beat = 0; wcnt = 0; pend = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (wb_valid) begin
        check({v.name, " latency"}, 64'(cyc), 64'(v.lat));
        check({v.name, " beats"}, 64'(beat), 64'(v.beats));
        check({v.name, " memres"}, 64'(wb_memres), 64'(v.memres));
        check({v.name, " err"}, 64'(wb_err), 64'(v.err));
        check({v.name, " regwrite"}, 64'(wb_regwrite), 64'(v.exp_rw));
        check({v.name, " rd"}, 64'(wb_rd), 64'(idx + 1));
        check({v.name, " alures"}, 64'(wb_alures), 64'(v.addr));
        check({v.name, " ready_after"}, 64'(ex_ready), 64'(1));
        if (v.beats == 0) check({v.name, " no_req"}, 64'(mem_req), 64'(0));
        done = 1'b1;
      end else begin
        check({v.name, " stall"}, 64'(ex_ready), 64'(0));
        if (pend) begin
          mem_rvalid = 1'b1;
          mem_rdata  = (beat == 0) ? v.rd0 : v.rd1;
          pend = 1'b0;
          beat++;
        end else if (mem_req) begin
          check({v.name, " addr"}, 64'(mem_addr), 64'((beat == 0) ? v.a0 : v.a1));
          check({v.name, " be"}, 64'(mem_be), 64'((beat == 0) ? v.be0 : v.be1));
          check({v.name, " wdata"}, 64'(mem_wdata), 64'(v.wd));
          check({v.name, " we"}, 64'(mem_we), 64'(v.wr_op));
          if (beat == 0 && wcnt < v.gnt_dly) wcnt++;
          else begin
            mem_gnt = 1'b1;
            pend = 1'b1;
          end
        end
      end
      if (!done) tick();
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL %s timeout: wb_valid not seen in 30 cycles", v.name);
    end else begin
      tick();
      check({v.name, " pulse"}, 64'(wb_valid), 64'(0));
    end
  endtask

  initial begin
    vecs[0]  = '{"lb",   1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80FF_0000, 32'h0,
                 0, 1, 32'h1000, 4'b1000, 32'h0, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1, 2, 1'b0};
    vecs[1]  = '{"lbu",  1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FF_0000, 32'h0,
                 0, 1, 32'h1000, 4'b1000, 32'h0, 4'b0000, 32'h0, 32'h0000_0080, 1'b0, 1'b1, 2, 1'b0};
    vecs[2]  = '{"sw_split", 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h2002, 32'hAABB_CCDD, 32'h0, 32'h0,
                 0, 2, 32'h2000, 4'b1100, 32'h2004, 4'b0011, 32'hCCDD_AABB, 32'h0, 1'b0, 1'b0, 4, 1'b0};
    vecs[3]  = '{"lw_split", 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h2002, 32'h0, 32'h1122_3344, 32'h5566_7788,
                 0, 2, 32'h2000, 4'b1100, 32'h2004, 4'b0011, 32'h0, 32'h7788_1122, 1'b0, 1'b1, 4, 1'b0};
    vecs[4]  = '{"lw_split_gntdly", 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h2002, 32'h0, 32'h1122_3344, 32'h5566_7788,
                 3, 2, 32'h2000, 4'b1100, 32'h2004, 4'b0011, 32'h0, 32'h7788_1122, 1'b0, 1'b1, 7, 1'b0};
    vecs[5]  = '{"lh",   1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h1002, 32'h0, 32'h8001_0000, 32'h0,
                 0, 1, 32'h1000, 4'b1100, 32'h0, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b0, 1'b1, 2, 1'b0};
    vecs[6]  = '{"lhu_split", 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 32'h1003, 32'h0, 32'hAB00_0000, 32'h0000_00CD,
                 0, 2, 32'h1000, 4'b1000, 32'h1004, 4'b0001, 32'h0, 32'h0000_CDAB, 1'b0, 1'b1, 4, 1'b0};
    vecs[7]  = '{"sb_fwd", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h1001, 32'h1234_5678, 32'h0, 32'h0,
                 0, 1, 32'h1000, 4'b0010, 32'h0, 4'b0000, 32'h3456_7812, 32'h0, 1'b0, 1'b0, 2, 1'b1};
    vecs[8]  = '{"ld_err", 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 32'h4000, 32'h0, 32'h0, 32'h0,
                 0, 0, 32'h0, 4'b0000, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0};
    vecs[9]  = '{"alu",  1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0044, 32'h0, 32'h0, 32'h0,
                 0, 0, 32'h0, 4'b0000, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 0, 1'b0};
    vecs[10] = '{"lw",   1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h3000, 32'h0, 32'hDEAD_BEEF, 32'h0,
                 0, 1, 32'h3000, 4'b1111, 32'h0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 2, 1'b0};

    Rst = 1'b0; dbg = 1'b0; ex_valid = 1'b0; ex_valid_na = 1'b0; fwd_en = 1'b0;
    ex_addr = '0; ex_wdata = '0; fwd_data = '0; ex_rd = '0; ex_regwrite = 1'b0;
    ex_memread = 1'b0; ex_memwrite = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #3;
    check("rst mem_req", 64'(mem_req), 64'(0));
    check("rst wb_valid", 64'(wb_valid), 64'(0));
    check("rst mem_be", 64'(mem_be), 64'(0));
    check("rst mem_addr", 64'(mem_addr), 64'(0));
    check("rst wb_memres", 64'(wb_memres), 64'(0));
    check("rst ex_ready", 64'(ex_ready), 64'(1));
    repeat (2) @(posedge clk);
    #1 Rst = 1'b1;

    // Back-to-back non-memory ops
    ex_regwrite = 1'b1; ex_rd = 5'd7; ex_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ex_addr = 32'(16 + 4 * k);
      check("b2b ready", 64'(ex_ready), 64'(1));
      tick();
      check("b2b wb_valid", 64'(wb_valid), 64'(1));
      check("b2b alures", 64'(wb_alures), 64'(16 + 4 * k));
    end
    ex_valid = 1'b0;
    tick();
    check("b2b end", 64'(wb_valid), 64'(0));

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // dbg raised in RSP0 of a single-beat load parks it in HOLD
    ex_memread = 1'b1; ex_memwrite = 1'b0; ex_regwrite = 1'b1; ex_size = 2'd0;
    ex_unsigned = 1'b0; ex_addr = 32'h1003; ex_rd = 5'd20; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    check("dbg req", 64'(mem_req), 64'(1));
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; dbg = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
    tick();
    mem_rvalid = 1'b0;
    check("dbg hold no_wb", 64'(wb_valid), 64'(0));
    check("dbg hold ready", 64'(ex_ready), 64'(0));
    tick();
    check("dbg hold2 no_wb", 64'(wb_valid), 64'(0));
    check("dbg hold2 no_req", 64'(mem_req), 64'(0));
    dbg = 1'b0;
    tick();
    check("dbg retire", 64'(wb_valid), 64'(1));
    check("dbg memres", 64'(wb_memres), 64'(32'hFFFF_FF80));
    check("dbg rd", 64'(wb_rd), 64'(20));
    tick();
    check("dbg pulse", 64'(wb_valid), 64'(0));
    check("dbg idle ready", 64'(ex_ready), 64'(1));

    // dbg in IDLE blocks accept
    ex_memread = 1'b0; ex_addr = 32'h88; dbg = 1'b1; ex_valid = 1'b1;
    #1;
    check("dbg ready low", 64'(ex_ready), 64'(0));
    tick();
    check("dbg no accept", 64'(wb_valid), 64'(0));
    dbg = 1'b0;
    tick();
    ex_valid = 1'b0;
    check("dbg late accept", 64'(wb_valid), 64'(1));
    check("dbg late alures", 64'(wb_alures), 64'(32'h88));

    // Instance without misaligned support
    ex_memread = 1'b0; ex_addr = 32'h50; ex_valid_na = 1'b1;
    tick();
    check("na alu valid", 64'(wb_valid_b), 64'(1));
    check("na alu err", 64'(wb_err_b), 64'(0));
    ex_memread = 1'b1; ex_size = 2'd1; ex_addr = 32'h3001;
    tick();
    check("na lh valid", 64'(wb_valid_b), 64'(1));
    check("na lh err", 64'(wb_err_b), 64'(1));
    check("na lh regwrite", 64'(wb_regwrite_b), 64'(0));
    check("na lh no_req", 64'(mem_req_b), 64'(0));
    ex_size = 2'd2; ex_addr = 32'h2002;
    tick();
    ex_valid_na = 1'b0;
    check("na lw err", 64'(wb_err_b), 64'(1));
    check("na lw no_req", 64'(mem_req_b), 64'(0));

    // Asynchronous reset during REQ0
    ex_memread = 1'b1; ex_size = 2'd2; ex_addr = 32'h3000; ex_rd = 5'd9; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    check("rstq req", 64'(mem_req), 64'(1));
    #2 Rst = 1'b0;
    #1;
    check("rstq mem_req", 64'(mem_req), 64'(0));
    check("rstq alures", 64'(wb_alures), 64'(0));
    check("rstq memres", 64'(wb_memres), 64'(0));
    check("rstq rd", 64'(wb_rd), 64'(0));
    check("rstq be", 64'(mem_be), 64'(0));
    #1 Rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rstq quiet", 64'({mem_req, wb_valid}), 64'(0));
    end
    check("rstq ready", 64'(ex_ready), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
